debug_sequencer: RTL and testbench

//  Host-side controller for the pipeline debug decoder. Accepts command bytes from a UART RX,

---
 rtl/debug_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_debug_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/debug_sequencer.sv
// Host-side debug sequencer: UART command bytes in, decoder readback / ACK bytes out, pipeline step gating.
// Optional feature: define DEBUG_SEQ_CHECKSUM_EN to append an XOR checksum byte after each READ response.
module debug_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  ACK_BYTE      = 8'hAA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  dbg_code,
  input  logic [31:0] dbg_result,
  input  logic [1:0]  dbg_size,
  output logic        step_en,
  output logic        running
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_SETTLE, S_LATCH, S_SEND, S_STEP, S_GETN, S_STEPN, S_RUN, S_ACK
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [1:0]    size_q, size_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    dbg_code_q, dbg_code_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          rx_ready_q, rx_ready_d;
  logic          step_en_q, step_en_d;
  logic          running_q, running_d;
  logic          rx_acc, tx_acc;

  // Index of the final byte of a READ response (checksum byte sits one past the data).
  function automatic logic [2:0] last_idx(input logic [1:0] sz);
`ifdef DEBUG_SEQ_CHECKSUM_EN
    return 3'({1'b0, sz}) + 3'd1;
`else
    return 3'({1'b0, sz});
`endif
  endfunction

`ifdef DEBUG_SEQ_CHECKSUM_EN
  function automatic logic [7:0] csum(input logic [31:0] s, input logic [1:0] sz);
    logic [7:0] x;
    x = s[7:0];
    if (sz >= 2'd1) x = x ^ s[15:8];
    if (sz >= 2'd2) x = x ^ s[23:16];
    if (sz == 2'd3) x = x ^ s[31:24];
    return x;
  endfunction
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    size_d     = size_q;
    idx_d      = idx_q;
    dbg_code_d = dbg_code_q;
    tx_data_d  = 8'h00;
    rx_acc     = rx_valid && rx_ready_q;
    tx_acc     = tx_valid_q && tx_ready;

    unique case (state_q)
      S_IDLE: begin
        if (rx_acc) begin
          if (!rx_data[7] && (rx_data != 8'h00)) begin
            dbg_code_d = rx_data;
            settle_d   = '0;
            state_d    = S_SETTLE;
          end else begin
            case (rx_data)
              8'hC0:   state_d = S_STEP;
              8'hC1:   state_d = S_GETN;
              8'hC2:   state_d = S_RUN;
              8'hC3:   state_d = S_ACK;
              default: state_d = S_IDLE;
            endcase
          end
        end
      end
      S_SETTLE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) state_d = S_LATCH;
        else settle_d = settle_q + SW'(1);
      end
      S_LATCH: begin
        shadow_d = dbg_result;
        size_d   = dbg_size;
        idx_d    = 3'd0;
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (tx_acc) begin
          if (idx_q == last_idx(size_q)) begin
            state_d    = S_IDLE;
            dbg_code_d = 8'h00;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_STEP: state_d = S_ACK;
      S_GETN: begin
        if (rx_acc) begin
          cnt_d   = rx_data;
          state_d = (rx_data == 8'h00) ? S_ACK : S_STEPN;
        end
      end
      S_STEPN: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = S_ACK;
      end
      S_RUN: begin
        if (rx_acc && (rx_data == 8'hC3)) state_d = S_ACK;
      end
      S_ACK: begin
        if (tx_acc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    rx_ready_d = (state_d == S_IDLE) || (state_d == S_GETN) || (state_d == S_RUN);
    tx_valid_d = (state_d == S_SEND) || (state_d == S_ACK);
    step_en_d  = (state_d == S_STEP) || (state_d == S_STEPN) || (state_d == S_RUN);
    running_d  = (state_d == S_RUN);

    if (state_d == S_ACK) begin
      tx_data_d = ACK_BYTE;
    end else if (state_d == S_SEND) begin
`ifdef DEBUG_SEQ_CHECKSUM_EN
      if (idx_d == last_idx(size_d)) tx_data_d = csum(shadow_d, size_d);
      else tx_data_d = shadow_d[{idx_d[1:0], 3'b000} +: 8];
`else
      tx_data_d = shadow_d[{idx_d[1:0], 3'b000} +: 8];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      settle_q   <= '0;
      cnt_q      <= 8'h00;
      shadow_q   <= 32'h0;
      size_q     <= 2'd0;
      idx_q      <= 3'd0;
      dbg_code_q <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      rx_ready_q <= 1'b1;
      step_en_q  <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      size_q     <= size_d;
      idx_q      <= idx_d;
      dbg_code_q <= dbg_code_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rx_ready_q <= rx_ready_d;
      step_en_q  <= step_en_d;
      running_q  <= running_d;
    end
  end

  assign rx_ready = rx_ready_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign dbg_code = dbg_code_q;
  assign step_en  = step_en_q;
  assign running  = running_q;

endmodule

// File: tb/tb_debug_sequencer.sv
// Directed bench for debug_sequencer: TX bytes scored against an expected-byte queue, step pulses counted.
module tb_debug_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  dbg_code;
  logic [31:0] dbg_result;
  logic [1:0]  dbg_size;
  logic        step_en;
  logic        running;

  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int n_assert = 0;
  int n_fail   = 0;
  int step_cnt = 0;
  int cur_run  = 0;
  int max_run  = 0;
  int n_extra  = 0;

  debug_sequencer dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .dbg_code(dbg_code), .dbg_result(dbg_result), .dbg_size(dbg_size),
    .step_en(step_en), .running(running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: score accepted TX bytes and track step_en pulses, sampled on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      if (step_en) begin
        step_cnt++;
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
      end else begin
        cur_run = 0;
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) n_extra++;
        else begin
          exp_b = exp_q.pop_front();
          check("tx_byte", 32'(tx_data), 32'(exp_b));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("rx_accept", 32'(rx_ready), 32'd1);
    cyc();
    rx_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || tx_valid) && k < 400) begin
      cyc();
      k++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_read(input logic [31:0] r, input logic [1:0] sz);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i <= int'(sz); i++) begin
      exp_q.push_back(r[8*i +: 8]);
      x = x ^ r[8*i +: 8];
    end
`ifdef DEBUG_SEQ_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
    dbg_result = 32'h0; dbg_size = 2'd0;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_step_en",  32'(step_en), 32'd0);
    check("rst_running",  32'(running), 32'd0);
    check("rst_dbg_code", 32'(dbg_code), 32'd0);
    check("rst_tx_data",  32'(tx_data), 32'd0);

    // 4-byte READ, LSB first, with latency and shadow-capture checks
    dbg_result = 32'h12345678; dbg_size = 2'd3;
    push_read(32'h12345678, 2'd3);
    send_byte(8'h0A);
    check("rd_dbg_code", 32'(dbg_code), 32'h0A);
    check("rd_lat_t1", 32'(tx_valid), 32'd0);
    cyc();
    check("rd_lat_t2", 32'(tx_valid), 32'd0);
    cyc();
    check("rd_lat_t3", 32'(tx_valid), 32'd0);
    cyc();
    check("rd_lat_t4", 32'(tx_valid), 32'd1);
    check("rd_first",  32'(tx_data), 32'h78);
    dbg_result = 32'hDEADBEEF;
    drain();
    cyc();
    check("rd_code_clr", 32'(dbg_code), 32'd0);
    check("rd_idle_rdy", 32'(rx_ready), 32'd1);
    check("rd_no_extra", 32'(n_extra), 32'd0);

    // 1-byte READ with TX back-pressure
    dbg_result = 32'h0000001F; dbg_size = 2'd0;
    tx_ready = 1'b0;
    push_read(32'h0000001F, 2'd0);
    send_byte(8'h0A);
    for (int k = 0; k < 20 && !tx_valid; k++) cyc();
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("stall_valid", 32'(tx_valid), 32'd1);
      check("stall_data",  32'(tx_data), 32'h1F);
    end
    tx_ready = 1'b1;
    drain();
    repeat (4) cyc();
    check("stall_no_dup", 32'(n_extra), 32'd0);

    // STEP, STEPN 3, STEPN 0
    step_cnt = 0; max_run = 0;
    exp_q.push_back(8'hAA);
    send_byte(8'hC0);
    drain();
    check("step_pulses", 32'(step_cnt), 32'd1);
    step_cnt = 0; max_run = 0;
    exp_q.push_back(8'hAA);
    send_byte(8'hC1);
    send_byte(8'h03);
    drain();
    check("stepn3_pulses", 32'(step_cnt), 32'd3);
    check("stepn3_consec", 32'(max_run), 32'd3);
    step_cnt = 0;
    exp_q.push_back(8'hAA);
    send_byte(8'hC1);
    send_byte(8'h00);
    drain();
    check("stepn0_pulses", 32'(step_cnt), 32'd0);

    // RUN, dropped byte, HALT
    send_byte(8'hC2);
    step_cnt = 0;
    repeat (20) cyc();
    check("run_pulses",  32'(step_cnt), 32'd20);
    check("run_running", 32'(running), 32'd1);
    send_byte(8'h0A);
    check("run_drop_running", 32'(running), 32'd1);
    check("run_drop_step",    32'(step_en), 32'd1);
    exp_q.push_back(8'hAA);
    send_byte(8'hC3);
    check("halt_step_en", 32'(step_en), 32'd0);
    check("halt_running", 32'(running), 32'd0);
    drain();
    repeat (3) cyc();
    check("run_no_extra", 32'(n_extra), 32'd0);

    // Reset while the second byte of a 4-byte response is pending
    dbg_result = 32'h12345678; dbg_size = 2'd3;
    push_read(32'h12345678, 2'd3);
    send_byte(8'h0A);
    for (int k = 0; k < 20 && !tx_valid; k++) cyc();
    cyc();
    tx_ready = 1'b0;
    check("mid_second_byte", 32'(tx_data), 32'h56);
    reset = 1'b1;
    cyc();
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_step_en",  32'(step_en), 32'd0);
    exp_q.delete();
    reset = 1'b0;
    tx_ready = 1'b1;
    cyc();
    dbg_result = 32'hAABBCCDD;
    push_read(32'hAABBCCDD, 2'd3);
    send_byte(8'h0A);
    drain();
    repeat (4) cyc();
    check("post_rst_no_extra", 32'(n_extra), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
